// File: rtl/prio_event_encoder.sv
// Registered N-channel event priority encoder: sticky pending capture, fixed or round-robin
// selection, valid/ready output stage. Define PRIO_EVT_COALESCE_CNT_EN to add coalesce_cnt.
module prio_event_encoder #(
  parameter int N = 16,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_in,
  input  logic [N-1:0]     mask_in,
  input  logic             rr_mode,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic [N-1:0]     pending,
  output logic             pend_any
`ifdef PRIO_EVT_COALESCE_CNT_EN
  ,
  output logic [7:0]       coalesce_cnt
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [N-1:0]     pending_reg, pending_next;
  logic [N-1:0]     eligible, below_last, clr;
  logic [IDX_W-1:0] out_idx_reg, out_idx_next;
  logic [IDX_W-1:0] last_reg, last_next;
  logic [IDX_W-1:0] fix_sel, low_sel, sel;
  logic             low_hit, load;
  logic             pend_any_reg;

  function automatic logic [IDX_W-1:0] highest(input logic [N-1:0] v);
    highest = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) highest = IDX_W'(i);
    end
  endfunction

  assign eligible = pending_reg & mask_in;

  // Set wins over clear so a pulse landing in its own load cycle is served again.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_chan
      assign below_last[gi]   = (IDX_W'(gi) < last_reg);
      assign pending_next[gi] = (pending_reg[gi] & ~clr[gi]) | req_in[gi];
    end
  endgenerate

  // Round-robin: highest eligible index below last, else wrap to the highest overall
  // (which is then necessarily >= last).
  assign fix_sel = highest(eligible);
  assign low_sel = highest(eligible & below_last);
  assign low_hit = |(eligible & below_last);
  assign sel     = (rr_mode && low_hit) ? low_sel : fix_sel;

  always_comb begin
    state_next   = state_reg;
    out_idx_next = out_idx_reg;
    last_next    = last_reg;
    clr          = '0;
    load         = (state_reg == EMPTY) || out_ready;
    if (load) begin
      if (|eligible) begin
        state_next   = FULL;
        out_idx_next = sel;
        last_next    = sel;
        clr[sel]     = 1'b1;
      end else begin
        state_next = EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= EMPTY;
      pending_reg  <= '0;
      out_idx_reg  <= '0;
      last_reg     <= '0;
      pend_any_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pending_reg  <= pending_next;
      out_idx_reg  <= out_idx_next;
      last_reg     <= last_next;
      pend_any_reg <= |pending_next;
    end
  end

  assign out_valid = (state_reg == FULL);
  assign out_idx   = out_idx_reg;
  assign pending   = pending_reg;
  assign pend_any  = pend_any_reg;

`ifdef PRIO_EVT_COALESCE_CNT_EN
  logic [7:0] coalesce_cnt_reg;
  logic       merged;

  // An event is lost when it hits an already-pending bit that is not cleared this cycle.
  assign merged = |(req_in & pending_reg & ~clr);

  always_ff @(posedge clk) begin
    if (rst) begin
      coalesce_cnt_reg <= '0;
    end else if (merged && (coalesce_cnt_reg != 8'hFF)) begin
      coalesce_cnt_reg <= coalesce_cnt_reg + 8'd1;
    end
  end

  assign coalesce_cnt = coalesce_cnt_reg;
`endif

endmodule

// File: tb/tb_prio_event_encoder.sv
// Directed, table-driven bench for prio_event_encoder (N=16): one row per clock cycle,
// plus hand-written latency and held-grant masking sequences.
module tb_prio_event_encoder;
  localparam int N = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_in;
  logic [N-1:0]  mask_in;
  logic          rr_mode;
  logic          out_ready;
  logic          out_valid;
  logic [3:0]    out_idx;
  logic [N-1:0]  pending;
  logic          pend_any;
`ifdef PRIO_EVT_COALESCE_CNT_EN
  logic [7:0]    coalesce_cnt;
`endif

  prio_event_encoder #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req_in),
    .mask_in   (mask_in),
    .rr_mode   (rr_mode),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .pending   (pending),
    .pend_any  (pend_any)
`ifdef PRIO_EVT_COALESCE_CNT_EN
    ,
    .coalesce_cnt (coalesce_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [15:0] req;
    logic [15:0] mask;
    logic        rr;
    logic        ready;
    logic        exp_valid;
    int          exp_idx;   // -1: index not checked
    logic [15:0] exp_pend;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [15:0] rq, input logic [15:0] mk,
                     input logic rrm, input logic rdy, input logic ev, input int ei,
                     input logic [15:0] ep, input logic [7:0] ec);
    vec_t v;
    v.rst = r; v.req = rq; v.mask = mk; v.rr = rrm; v.ready = rdy;
    v.exp_valid = ev; v.exp_idx = ei; v.exp_pend = ep; v.exp_cnt = ec;
    vq.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst = 1'b1; req_in = '0; mask_in = '0; rr_mode = 1'b0; out_ready = 1'b0;

    // basic fixed priority
    add(1, 16'h0000, 16'h0000, 0, 0, 0,  0, 16'h0000, 0);
    add(0, 16'h8001, 16'hFFFF, 0, 1, 0, -1, 16'h8001, 0);
    add(0, 16'h0000, 16'hFFFF, 0, 1, 1, 15, 16'h0001, 0);
    add(0, 16'h0000, 16'hFFFF, 0, 1, 1,  0, 16'h0000, 0);
    add(0, 16'h0000, 16'hFFFF, 0, 1, 0, -1, 16'h0000, 0);
    // backpressure: idx 3 held for five cycles, then 3 accepted and 9 follows
    add(0, 16'h0008, 16'hFFFF, 0, 0, 0, -1, 16'h0008, 0);
    add(0, 16'h0200, 16'hFFFF, 0, 0, 1,  3, 16'h0200, 0);
    for (int k = 0; k < 4; k++) add(0, 16'h0000, 16'hFFFF, 0, 0, 1, 3, 16'h0200, 0);
    add(0, 16'h0000, 16'hFFFF, 0, 1, 1,  9, 16'h0000, 0);
    add(0, 16'h0000, 16'hFFFF, 0, 1, 0, -1, 16'h0000, 0);
    // round-robin from reset, then fixed mode with the same stimulus
    add(1, 16'h0000, 16'hFFFF, 1, 1, 0,  0, 16'h0000, 0);
    add(0, 16'hFFFF, 16'hFFFF, 1, 1, 0, -1, 16'hFFFF, 0);
    for (int k = 0; k <= 16; k++)
      add(0, 16'hFFFF, 16'hFFFF, 1, 1, 1, (k == 16) ? 15 : 15 - k, 16'hFFFF, 8'(k + 1));
    for (int k = 0; k < 4; k++)
      add(0, 16'hFFFF, 16'hFFFF, 0, 1, 1, 15, 16'hFFFF, 8'(18 + k));
    add(1, 16'hFFFF, 16'hFFFF, 0, 1, 0,  0, 16'h0000, 0);
    // masking
    add(0, 16'h8010, 16'h7FFF, 0, 1, 0, -1, 16'h8010, 0);
    add(0, 16'h0000, 16'h7FFF, 0, 1, 1,  4, 16'h8000, 0);
    add(0, 16'h0000, 16'h7FFF, 0, 1, 0, -1, 16'h8000, 0);
    add(0, 16'h0000, 16'hFFFF, 0, 1, 1, 15, 16'h0000, 0);
    add(0, 16'h0000, 16'hFFFF, 0, 1, 0, -1, 16'h0000, 0);
    // set over clear: idx 7 granted twice; then one merged pulse while masked
    add(0, 16'h0080, 16'hFFFF, 0, 1, 0, -1, 16'h0080, 0);
    add(0, 16'h0080, 16'hFFFF, 0, 1, 1,  7, 16'h0080, 0);
    add(0, 16'h0000, 16'hFFFF, 0, 1, 1,  7, 16'h0000, 0);
    add(0, 16'h0000, 16'hFFFF, 0, 1, 0, -1, 16'h0000, 0);
    add(0, 16'h0080, 16'h0000, 0, 1, 0, -1, 16'h0080, 0);
    add(0, 16'h0080, 16'h0000, 0, 1, 0, -1, 16'h0080, 1);
    add(0, 16'h0000, 16'hFFFF, 0, 1, 1,  7, 16'h0000, 1);
    add(0, 16'h0000, 16'hFFFF, 0, 1, 0, -1, 16'h0000, 1);
    // reset mid-operation with all requests asserted
    add(0, 16'h0400, 16'hFFFF, 0, 0, 0, -1, 16'h0400, 1);
    add(0, 16'h0130, 16'hFFFF, 0, 0, 1, 10, 16'h0130, 1);
    add(1, 16'hFFFF, 16'hFFFF, 0, 1, 0,  0, 16'h0000, 0);
    add(0, 16'h0000, 16'hFFFF, 0, 1, 0,  0, 16'h0000, 0);

    for (int i = 0; i < vq.size(); i++) begin
      rst = vq[i].rst; req_in = vq[i].req; mask_in = vq[i].mask;
      rr_mode = vq[i].rr; out_ready = vq[i].ready;
      tick();
      $display("vec %0d: rst=%0b req=%h mask=%h rr=%0b rdy=%0b -> valid=%0b idx=%0d pending=%h any=%0b",
               i, rst, req_in, mask_in, rr_mode, out_ready, out_valid, out_idx, pending, pend_any);
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vq[i].exp_valid));
      if (vq[i].exp_idx >= 0)
        check($sformatf("vec%0d_idx", i), 32'(out_idx), 32'(vq[i].exp_idx));
      check($sformatf("vec%0d_pending", i), 32'(pending), 32'(vq[i].exp_pend));
      check($sformatf("vec%0d_pend_any", i), 32'(pend_any), 32'(|vq[i].exp_pend));
`ifdef PRIO_EVT_COALESCE_CNT_EN
      check($sformatf("vec%0d_coalesce", i), 32'(coalesce_cnt), 32'(vq[i].exp_cnt));
`endif
    end

    // latency: request at edge t is granted at edge t+2, bounded wait
    rst = 1'b0; mask_in = 16'hFFFF; rr_mode = 1'b0; out_ready = 1'b1; req_in = 16'h0020;
    tick();
    req_in = '0;
    n = 1;
    while (!out_valid && n < 5) begin
      tick();
      n++;
    end
    $display("latency: edges=%0d valid=%0b idx=%0d", n, out_valid, out_idx);
    check("latency_edges", 32'(n), 32'd2);
    check("latency_idx", 32'(out_idx), 32'd5);
    tick();
    $display("latency drain: valid=%0b", out_valid);
    check("latency_drain", 32'(out_valid), 32'd0);

    // masking the held grant does not revoke it
    out_ready = 1'b0; req_in = 16'h0004;
    tick();
    req_in = '0;
    tick();
    $display("held grant: valid=%0b idx=%0d", out_valid, out_idx);
    check("held_valid", 32'(out_valid), 32'd1);
    check("held_idx", 32'(out_idx), 32'd2);
    mask_in = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      $display("held masked %0d: valid=%0b idx=%0d", k, out_valid, out_idx);
      check($sformatf("held_masked%0d_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("held_masked%0d_idx", k), 32'(out_idx), 32'd2);
    end
    out_ready = 1'b1; mask_in = 16'hFFFF;
    tick();
    $display("held accepted: valid=%0b pending=%h", out_valid, pending);
    check("held_accept_valid", 32'(out_valid), 32'd0);
    check("held_accept_pending", 32'(pending), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prio_event_encoder.md
Name: prio_event_encoder

Overview:
- Parametrised, registered successor to the combinational 16-input priority encoder.
- Captures one-cycle request pulses from N channels into a sticky pending register. Emits one channel index per handshake on a valid/ready output stage.
- Two run-time modes: fixed priority (highest index wins) and round-robin.
- Sits between event sources (buttons, IRQ-like pulses on ui_in/uio_in) and a downstream consumer that may stall.

Parameters:
- N, 16, number of request channels; legal range 2..64.
- IDX_W, $clog2(N), index width; local, derived, not overridable.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req_in  in  N  one-cycle event pulses; bit i = event on channel i.
- mask_in  in  N  1 = channel eligible for selection; 0 = held back.
- rr_mode  in  1  0 = fixed priority (highest index); 1 = round-robin.
- out_ready  in  1  consumer accepts out_idx this cycle.
- out_valid  out  1  out_idx holds a granted channel.
- out_idx  out  IDX_W  granted channel index.
- pending  out  N  registered pending-event vector.
- pend_any  out  1  registered OR of pending (mask ignored).

Behaviour:
- Reset (rst=1 at an edge) sets: pending=0, out_valid=0, out_idx=0, rr pointer last=0, pend_any=0.
- req_in is ignored in any cycle where rst=1.
- Reset mid-operation discards the held grant and all pending events; no handshake completes in that cycle.
- Pending update: pending_next = (pending & ~clr) | req_in.
  - clr is the one-hot of the index loaded this cycle, else 0.
  - Set wins over clear: a req_in bit arriving in its own load cycle stays pending and is served again later.
  - req_in is captured regardless of mask_in.
- Output stage has two states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1, out_idx stable, pending keeps accumulating).
- Load condition is EMPTY, or FULL with out_valid & out_ready. Selection uses the registered pending only, with no bypass from req_in.
  - If (pending & mask_in) != 0: load the selected index, clear its pending bit, set last=index, go to or stay FULL.
  - Otherwise: go to EMPTY.
- Latency: req_in at edge t -> pending at t+1 -> out_valid at t+2 at the earliest. Back-to-back grants are possible, one per cycle while out_ready=1.
- Fixed mode: select the highest set index of pending & mask_in.
- Round-robin mode:
  - Search descending from last-1 down to 0, then wrap from N-1 down to last.
  - With last=0 after reset, the first selection equals fixed priority.
  - last updates in both modes. An rr_mode change applies to the next selection.
- Masking:
  - Deasserting mask_in[i] while pending[i]=1 keeps the bit pending, unserved until unmasked.
  - Deasserting mask for the currently held out_idx has no effect; the grant stays valid until accepted.
- pend_any reflects the registered pending. It is 1 while masked events remain.

Optional Feature:
- Macro PRIO_EVT_COALESCE_CNT_EN.
- Defined:
  - Adds output coalesce_cnt [7:0], reset to 0.
  - Increments by 1 in each cycle where some bit i has req_in[i]=1 and pending[i]=1, and i is not being cleared that cycle (an event merged and lost).
  - Saturates at 255.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Basic fixed priority: rst, then rr_mode=0, mask=FFFF, out_ready=1, req_in=16'h8001 for 1 cycle -> out_valid=1 with idx 15 two edges later, idx 0 next cycle, then out_valid=0 and pending=0.
- Backpressure: out_ready=0, req bit 3 at t, bit 9 at t+1 -> idx 3 held stable for 5 cycles. Raise out_ready -> idx 3 accepted, then idx 9.
- Round-robin: rr_mode=1, req_in=FFFF every cycle, out_ready=1 -> idx sequence 15,14,...,1,0,15. The same stimulus with rr_mode=0 -> 15 every cycle.
- Mask: mask=7FFF, req bits 15 and 4 -> only idx 4 granted, pending=8000 and pend_any=1. Set mask=FFFF -> idx 15 granted.
- Set-over-clear: req bit 7 pulsed exactly in the cycle idx 7 is loaded -> idx 7 granted twice. With PRIO_EVT_COALESCE_CNT_EN, a repeated bit-7 pulse while pending -> coalesce_cnt=1.
- Reset mid-op: out_valid=1, pending=0x0130, rst=1 for 1 cycle with req_in=FFFF -> next cycle out_valid=0, pending=0, out_idx=0.
